// File: rtl/gpio_irq.sv
// Wishbone GPIO controller: per-bit direction, atomic SET/CLR of outputs,
// synchronised inputs and latched per-bit edge interrupts on one level irq.
module gpio_irq #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  DIR_RST     = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic [31:0]      adr_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_RISE = 3'd4;
    localparam logic [2:0] A_FALL = 3'd5;
    localparam logic [2:0] A_STAT = 3'd6;
    localparam logic [2:0] A_IN   = 3'd7;

    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] in_p_q, in_p_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic             ack_q,  ack_d;
    logic             irq_q,  irq_d;

    logic [DW-1:0]    lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] rd_data;
    logic [2:0]       reg_sel;
    logic             wr_en;

    // Address bits outside [4:2] and data bits above WIDTH are don't-care.
    logic             unused_ok;
    assign unused_ok = ^{adr_i[31:5], adr_i[1:0], dat_i};

    always_comb begin
        lane_mask = '0;
        for (int n = 0; n < 4; n++) begin
            lane_mask[8*n +: 8] = {8{sel_i[n]}};
        end
    end

    assign wmask   = lane_mask[WIDTH-1:0];
    assign wdata   = dat_i[WIDTH-1:0] & wmask;
    assign reg_sel = adr_i[4:2];
    // Only the strobe cycle before the ack applies the write, so it lands once.
    assign wr_en   = cyc_i & stb_i & we_i & ~ack_q;

    assign in_s     = sync_q[SYNC_STAGES-1];
    assign edge_evt = ~dir_q & ((rise_q & in_s & ~in_p_q) | (fall_q & ~in_s & in_p_q));

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr_en) begin
            case (reg_sel)
                A_OUT:   out_d  = (out_q  & ~wmask) | wdata;
                A_DIR:   dir_d  = (dir_q  & ~wmask) | wdata;
                A_SET:   out_d  = out_q | wdata;
                A_CLR:   out_d  = out_q & ~wdata;
                A_RISE:  rise_d = (rise_q & ~wmask) | wdata;
                A_FALL:  fall_d = (fall_q & ~wmask) | wdata;
                A_STAT:  stat_d = stat_q & ~wdata;
                default: ;
            endcase
        end
        // A new edge overrides a same-cycle W1C on that bit.
        stat_d = stat_d | edge_evt;
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};
        in_p_d = in_s;
        ack_d  = cyc_i & stb_i & ~ack_q;
        irq_d  = |stat_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q  <= '0;
            dir_q  <= DIR_RST;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            sync_q <= '0;
            in_p_q <= '0;
            ack_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
            sync_q <= sync_d;
            in_p_q <= in_p_d;
            ack_q  <= ack_d;
            irq_q  <= irq_d;
        end
    end

    // Read mux is combinational so the data is valid alongside the ack.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            A_OUT:   rd_data = out_q;
            A_DIR:   rd_data = dir_q;
            A_RISE:  rd_data = rise_q;
            A_FALL:  rd_data = fall_q;
            A_STAT:  rd_data = stat_q;
            A_IN:    rd_data = in_s;
            default: rd_data = '0;
        endcase
    end

    assign dat_o     = DW'(rd_data);
    assign ack_o     = ack_q;
    assign irq_o     = irq_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios plus random bus/pin
// traffic compared each cycle against a behavioural register/edge model.
module tb_gpio_irq;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_w = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_r, dat_r3;
    logic        ack, ack3, irq, irq3;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out, gpio_oe;
    logic [2:0]  g3_in = 3'b101;
    logic [2:0]  g3_out, g3_oe;

    gpio_irq #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .we_i(we), .sel_i(sel), .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack),
        .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
    );

    gpio_irq #(.WIDTH(3), .SYNC_STAGES(SYNC)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .we_i(we), .sel_i(sel), .dat_i(dat_w), .dat_o(dat_r3), .ack_o(ack3),
        .gpio_i(g3_in), .gpio_o(g3_out), .gpio_oe_o(g3_oe), .irq_o(irq3)
    );

    always #5 if (clk_en) clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the 8-bit instance
    logic [7:0]  m_out, m_dir, m_rise, m_fall, m_stat;
    logic        m_irq, m_ack;
    logic [7:0]  hist [0:SYNC];   // hist[k] = pin value sampled k+1 edges ago
    logic [31:0] rd3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = 8'hFF; m_rise = '0; m_fall = '0; m_stat = '0;
        m_irq = 1'b0; m_ack = 1'b0;
        for (int k = 0; k <= SYNC; k++) hist[k] = '0;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0: return 32'(m_out);
            1: return 32'(m_dir);
            4: return 32'(m_rise);
            5: return 32'(m_fall);
            6: return 32'(m_stat);
            7: return 32'(hist[SYNC-1]);
            default: return 32'h0;
        endcase
    endfunction

    // One clock: predict next state from present inputs, clock, then compare.
    task automatic step();
        logic [7:0] n_out, n_dir, n_rise, n_fall, n_stat, wm, wd, evt, ins, inp, pin;
        logic       n_irq, n_ack, wr;
        ins = hist[SYNC-1];
        inp = hist[SYNC];
        evt = '0;
        for (int b = 0; b < 8; b++) begin
            wm[b] = sel[b / 8];
            if (!m_dir[b] && m_rise[b] && ins[b] && !inp[b]) evt[b] = 1'b1;
            if (!m_dir[b] && m_fall[b] && !ins[b] && inp[b]) evt[b] = 1'b1;
        end
        wd = dat_w[7:0] & wm;
        n_out = m_out; n_dir = m_dir; n_rise = m_rise; n_fall = m_fall; n_stat = m_stat;
        wr = cyc && stb && we && !m_ack;
        if (wr) begin
            case (adr[4:2])
                3'd0: n_out  = (m_out & ~wm) | wd;
                3'd1: n_dir  = (m_dir & ~wm) | wd;
                3'd2: n_out  = m_out | wd;
                3'd3: n_out  = m_out & ~wd;
                3'd4: n_rise = (m_rise & ~wm) | wd;
                3'd5: n_fall = (m_fall & ~wm) | wd;
                3'd6: n_stat = m_stat & ~wd;
                default: ;
            endcase
        end
        n_stat = n_stat | evt;
        n_irq  = (m_stat != 8'h00);
        n_ack  = cyc && stb && !m_ack;
        pin    = gpio_in;
        @(posedge clk);
        #1;
        m_out = n_out; m_dir = n_dir; m_rise = n_rise; m_fall = n_fall; m_stat = n_stat;
        m_irq = n_irq; m_ack = n_ack;
        for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = pin;
        check("gpio_o", 32'(gpio_out), 32'(m_out));
        check("gpio_oe_o", 32'(gpio_oe), 32'(m_dir));
        check("irq_o", 32'(irq), 32'(m_irq));
        check("ack_o", 32'(ack), 32'(m_ack));
    endtask

    task automatic bus(input logic w, input int idx, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_w = d;
        adr = {27'($urandom), 3'(idx), 2'($urandom)};
        step();
        check("ack_pulse", 32'(ack), 32'h1);
        check("ack_w3", 32'(ack3), 32'h1);
        rd  = dat_r;
        rd3 = dat_r3;
        if (!w) check("rd_data", dat_r, m_read(idx));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        logic [31:0] tmp;
        bus(1'b1, idx, 4'hF, d, tmp);
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        bus(1'b0, idx, 4'hF, 32'h0, d);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp3 [0:7];

        // Reset defaults with the clock stopped
        #2 rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_oe", 32'(gpio_oe), 32'hFF);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_oe_w3", 32'(g3_oe), 32'h7);
        clk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(1, v); check("dir_rst", v, 32'hFF);
        rd(6, v); check("stat_rst", v, 32'h0);

        // Plain write, SET, CLR, empty byte mask
        wr(0, 32'hA5); check("out_a5", 32'(gpio_out), 32'hA5);
        wr(2, 32'h0A); check("set_0a", 32'(gpio_out), 32'hAF);
        wr(3, 32'h81); check("clr_81", 32'(gpio_out), 32'h2E);
        bus(1'b1, 0, 4'b0000, 32'hFF, v); check("sel0", 32'(gpio_out), 32'h2E);

        // Strobe held across SET then CLR of bit 6: ack every second cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat_w = 32'h40; adr = 32'h08;
        step(); check("hold_set", 32'(gpio_out), 32'h6E);
        adr = 32'h0C;
        step(); check("hold_gap", 32'(ack), 32'h0);
        step(); check("hold_clr", 32'(gpio_out), 32'h2E);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();

        // Rising edge: STAT after 3 edges, irq after 4, W1C drops irq
        wr(1, 32'hF0);
        wr(4, 32'h01);
        gpio_in[0] = 1'b1;
        repeat (3) step();
        check("rise_irq_e3", 32'(irq), 32'h0);
        step();
        check("rise_irq_e4", 32'(irq), 32'h1);
        rd(6, v); check("rise_stat", v, 32'h01);
        wr(6, 32'h01); check("w1c_irq", 32'(irq), 32'h0);

        // Same transition with the bit as an output: no event
        wr(1, 32'hF1);
        gpio_in[0] = 1'b0; repeat (4) step();
        gpio_in[0] = 1'b1; repeat (4) step();
        rd(6, v); check("out_noevt", v, 32'h0);
        wr(1, 32'hF0);
        repeat (2) step();
        check("dir_noevt", 32'(irq), 32'h0);

        // Falling edge, then a second fall colliding with W1C
        wr(5, 32'h02);
        gpio_in[1] = 1'b1; repeat (4) step();
        gpio_in[1] = 1'b0; repeat (4) step();
        check("fall_irq", 32'(irq), 32'h1);
        gpio_in[1] = 1'b1; repeat (4) step();
        gpio_in[1] = 1'b0;
        step(); step();
        wr(6, 32'h02);
        check("coll_irq", 32'(irq), 32'h1);
        rd(6, v); check("coll_stat", v, 32'h02);
        wr(6, 32'h02); check("coll_clr", 32'(irq), 32'h0);

        // One-cycle pin pulse sets STAT exactly once
        wr(4, 32'h05);
        gpio_in[2] = 1'b1; step();
        gpio_in[2] = 1'b0; repeat (6) step();
        rd(6, v); check("glitch_stat", v, 32'h04);
        wr(6, 32'h04);
        repeat (4) step();
        rd(6, v); check("glitch_once", v, 32'h0);

        // IN lags the pins by the synchroniser depth
        gpio_in = 8'h5A;
        rd(7, v); check("in_old", v, 32'h01);
        rd(7, v); check("in_new", v, 32'h5A);

        // Reset in the middle of a write strobe
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat_w = 32'h55; adr = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_ack", 32'(ack), 32'h0);
        check("mid_out", 32'(gpio_out), 32'h0);
        check("mid_oe", 32'(gpio_oe), 32'hFF);
        @(posedge clk); #1 check("mid_ack_e1", 32'(ack), 32'h0);
        @(posedge clk); #1 check("mid_out_e2", 32'(gpio_out), 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        rd(0, v); check("mid_out_rd", v, 32'h0);

        // Random traffic against the model
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 2) == 0) gpio_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0: step();
                1: bus(1'b1, int'($urandom_range(0, 7)), 4'($urandom), $urandom, v);
                default: bus(1'b0, int'($urandom_range(0, 7)), 4'hF, 32'h0, v);
            endcase
        end

        // Narrow build: bits above WIDTH read 0 in every register
        wr(6, 32'hFFFF_FFFF);
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        wr(4, 32'hFFFF_FFFF);
        wr(5, 32'hFFFF_FFFF);
        wr(6, 32'hFFFF_FFFF);
        exp3[0] = 32'h7; exp3[1] = 32'h7; exp3[2] = 32'h0; exp3[3] = 32'h0;
        exp3[4] = 32'h7; exp3[5] = 32'h7; exp3[6] = 32'h0; exp3[7] = 32'h5;
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            check("w3_reg", rd3, exp3[i]);
        end
        check("w3_gpio_o", 32'(g3_out), 32'h7);
        check("w3_oe", 32'(g3_oe), 32'h7);
        check("w3_irq", 32'(irq3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
